instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the reset port SHALL be named `reset`.
REQ-002 Ports SHALL be as follows:
  - clk  input  1: clock; all state changes on rising edge.
  - reset  input  1: asynchronous, active-low reset.
  - mem_data  input  8: instruction byte read from instruction memory at pc_in.
  - mem_valid  input  1: mem_data valid this cycle.
  - pc_in  input  8: address of the byte currently on mem_data.
  - flush  input  1: PC was loaded this cycle (branch, LOOP, JMP/CALL, RET/RTI, interrupt, reset vector).
  - id_ready  input  1: decode stage accepts the held instruction this cycle.
  - fetch_req  output  1: buffer can accept a byte this cycle; drives PC increment.
  - if_valid  output  1: a complete instruction is held.
  - if_opcode  output  4: byte1[7:4].
  - if_ra  output  2: byte1[3:2]; this is the brx field for opcodes 9 and 11.
  - if_rb  output  2: byte1[1:0].
  - if_imm  output  8: byte2 for two-byte instructions; 8'h00 otherwise.
  - if_two_byte  output  1: held instruction is two bytes.
  - if_pc  output  8: pc_in captured with byte1.

Function
REQ-003 The state machine SHALL have three states: EMPTY, HALF (byte1 of a two-byte instruction held) and FULL (complete instruction held).
REQ-004 A byte is accepted iff mem_valid=1, fetch_req=1 and flush=0.
REQ-005 fetch_req SHALL be !flush && (state==EMPTY || state==HALF || (state==FULL && id_ready)).
REQ-006 An instruction is two bytes iff byte1[7:4]==4'd12; all other opcodes are one byte.
REQ-007 EMPTY, byte accepted:
  - one-byte opcode: capture byte1 and pc_in, set if_imm=0, go to FULL;
  - opcode 12: capture byte1 and pc_in, go to HALF.
REQ-008 HALF, byte accepted: capture byte as if_imm, set if_two_byte=1, go to FULL.
REQ-009 HALF, no byte accepted: remain in HALF.
REQ-010 FULL, id_ready=0: hold all outputs stable and accept nothing.
REQ-011 FULL, id_ready=1 and a byte accepted: load the new byte as byte1 in the same cycle and transition per REQ-007 with zero bubble.
REQ-012 FULL, id_ready=1 and no byte accepted: go to EMPTY.
REQ-013 if_valid SHALL be 1 only in FULL; there is one cycle of latency from acceptance of the final byte to if_valid=1.
REQ-014 flush SHALL override every other input: next state is EMPTY, any partial or held instruction is discarded, and mem_data in the flush cycle is ignored.
REQ-015 Outputs SHALL be registered; if_* fields SHALL change only when byte1 or byte2 is captured, or on flush or reset.
REQ-016 If mem_valid=1 while fetch_req=0, the byte is not consumed; memory SHALL re-present it, and the PC is not incremented because fetch_req=0.
REQ-017 pc_in SHALL be captured unmodified and SHALL NOT be arithmetically modified; 8'hFF followed by 8'h00 is legal wrap-around.

Reset
REQ-018 While reset=0, state SHALL be EMPTY and if_valid=0, if_opcode=0, if_ra=0, if_rb=0, if_imm=0, if_two_byte=0, if_pc=0, asynchronously.
REQ-019 While reset=0, fetch_req SHALL be 0.
REQ-020 Reset asserted mid-instruction (HALF or FULL) SHALL discard the instruction, with no output glitch to if_valid=1.
REQ-021 After reset deasserts, the first rising edge SHALL see fetch_req=1, provided flush=0.

Verification
REQ-022 One-byte instruction: mem_data=8'h96, pc_in=8'h10, mem_valid=1, id_ready=0 -> next cycle if_valid=1, if_opcode=9, if_ra=1, if_rb=2, if_pc=8'h10, if_imm=0, fetch_req=0.
REQ-023 Two-byte LDM: bytes 8'hC4 at pc_in=8'h20 then 8'h5A at 8'h21 -> HALF after byte 1 with if_valid=0; then if_valid=1, if_opcode=12, if_imm=8'h5A, if_two_byte=1, if_pc=8'h20.
REQ-024 Back-to-back instructions: FULL, id_ready=1, mem_data=8'h11 valid -> next cycle if_valid=1, if_opcode=1, no empty cycle between instructions.
REQ-025 Flush in HALF: after 8'hC0 is accepted, flush=1 with mem_data=8'h77 -> next cycle EMPTY, if_valid=0, and 8'h77 not captured.
REQ-026 Stall: FULL with id_ready=0 for 5 cycles and mem_valid=1 -> outputs unchanged and fetch_req=0 throughout.
REQ-027 Async reset: reset=0 asserted mid-cycle in FULL -> if_valid=0 and all fields zero before the next clock edge.

Source files
------------

// File: rtl/instr_fetch_buffer_if.sv
// rtl/instr_fetch_buffer_if.sv - fetch/decode handshake bundle for the instruction fetch buffer
interface instr_fetch_buffer_if;
  logic [7:0] mem_data;
  logic       mem_valid;
  logic [7:0] pc_in;
  logic       flush;
  logic       id_ready;
  logic       fetch_req;
  logic       if_valid;
  logic [3:0] if_opcode;
  logic [1:0] if_ra;
  logic [1:0] if_rb;
  logic [7:0] if_imm;
  logic       if_two_byte;
  logic [7:0] if_pc;

  // Surrounding pipeline: memory, PC logic and decode stage
  modport master (
    output mem_data, mem_valid, pc_in, flush, id_ready,
    input  fetch_req, if_valid, if_opcode, if_ra, if_rb, if_imm, if_two_byte, if_pc
  );

  // The fetch buffer itself
  modport slave (
    input  mem_data, mem_valid, pc_in, flush, id_ready,
    output fetch_req, if_valid, if_opcode, if_ra, if_rb, if_imm, if_two_byte, if_pc
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - byte-wide fetch buffer assembling one/two-byte instructions
module instr_fetch_buffer (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_buffer_if.slave   fb
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   fetch_ok;
  logic   accept;
  logic   load_byte1;
  logic   load_byte2;
  logic   is_two_byte;

  // Opcode 12 (LDM) carries an immediate byte; everything else is single byte
  assign is_two_byte  = (fb.mem_data[7:4] == 4'd12);
  assign fb.fetch_req = fetch_ok;

  // State register; reset drops any partial or held instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, byte acceptance and capture enables; flush wins over everything
  always_comb begin
    state_nxt  = state;
    load_byte1 = 1'b0;
    load_byte2 = 1'b0;
    // fetch_req is gated by reset so the PC never advances while held in reset
    fetch_ok   = reset && !fb.flush && ((state != FULL) || fb.id_ready);
    accept     = fetch_ok && fb.mem_valid;
    if (fb.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_byte1 = 1'b1;
            state_nxt  = is_two_byte ? HALF : FULL;
          end
        end
        HALF: begin
          if (accept) begin
            load_byte2 = 1'b1;
            state_nxt  = FULL;
          end
        end
        FULL: begin
          if (fb.id_ready) begin
            if (accept) begin
              // Decode takes the held instruction while the next byte1 lands: no bubble
              load_byte1 = 1'b1;
              state_nxt  = is_two_byte ? HALF : FULL;
            end else begin
              state_nxt = EMPTY;
            end
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Registered instruction fields; they move only on capture, flush or reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb.if_valid    <= 1'b0;
      fb.if_opcode   <= 4'd0;
      fb.if_ra       <= 2'd0;
      fb.if_rb       <= 2'd0;
      fb.if_imm      <= 8'h00;
      fb.if_two_byte <= 1'b0;
      fb.if_pc       <= 8'h00;
    end else begin
      fb.if_valid <= (state_nxt == FULL);
      if (fb.flush) begin
        fb.if_opcode   <= 4'd0;
        fb.if_ra       <= 2'd0;
        fb.if_rb       <= 2'd0;
        fb.if_imm      <= 8'h00;
        fb.if_two_byte <= 1'b0;
        fb.if_pc       <= 8'h00;
      end else if (load_byte1) begin
        fb.if_opcode   <= fb.mem_data[7:4];
        fb.if_ra       <= fb.mem_data[3:2];
        fb.if_rb       <= fb.mem_data[1:0];
        fb.if_imm      <= 8'h00;
        fb.if_two_byte <= 1'b0;
        fb.if_pc       <= fb.pc_in;
      end else if (load_byte2) begin
        fb.if_imm      <= fb.mem_data;
        fb.if_two_byte <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - directed scoreboard bench for instr_fetch_buffer
module tb_instr_fetch_buffer;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] imm;
    logic       two;
    logic [7:0] pc;
  } instr_t;

  logic   clk;
  logic   reset;
  int     vectors;
  int     miscompares;
  instr_t sb[$];

  instr_fetch_buffer_if fb();

  instr_fetch_buffer dut (
    .clk   (clk),
    .reset (reset),
    .fb    (fb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mk1(input logic [7:0] b1, input logic [7:0] pc);
    instr_t e;
    e.op  = b1[7:4];
    e.ra  = b1[3:2];
    e.rb  = b1[1:0];
    e.imm = 8'h00;
    e.two = 1'b0;
    e.pc  = pc;
    return e;
  endfunction

  function automatic instr_t mk2(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] pc);
    instr_t e;
    e     = mk1(b1, pc);
    e.imm = b2;
    e.two = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] pc, input logic rdy);
    fb.mem_valid = v;
    fb.mem_data  = d;
    fb.pc_in     = pc;
    fb.id_ready  = rdy;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, fb.if_valid}, 32'd0);
    chk({tag, ".op"},    {28'd0, fb.if_opcode}, 32'd0);
    chk({tag, ".ra"},    {30'd0, fb.if_ra}, 32'd0);
    chk({tag, ".rb"},    {30'd0, fb.if_rb}, 32'd0);
    chk({tag, ".imm"},   {24'd0, fb.if_imm}, 32'd0);
    chk({tag, ".two"},   {31'd0, fb.if_two_byte}, 32'd0);
    chk({tag, ".pc"},    {24'd0, fb.if_pc}, 32'd0);
  endtask

  // Compare held instruction against scoreboard head; pop when decode takes it
  task automatic chk_front(input string tag, input bit pop);
    instr_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb[0];
      chk({tag, ".valid"}, {31'd0, fb.if_valid}, 32'd1);
      chk({tag, ".op"},    {28'd0, fb.if_opcode}, {28'd0, e.op});
      chk({tag, ".ra"},    {30'd0, fb.if_ra}, {30'd0, e.ra});
      chk({tag, ".rb"},    {30'd0, fb.if_rb}, {30'd0, e.rb});
      chk({tag, ".imm"},   {24'd0, fb.if_imm}, {24'd0, e.imm});
      chk({tag, ".two"},   {31'd0, fb.if_two_byte}, {31'd0, e.two});
      chk({tag, ".pc"},    {24'd0, fb.if_pc}, {24'd0, e.pc});
      if (pop) void'(sb.pop_front());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    fb.flush    = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);

    // Reset state
    #3;
    chk_zero("reset");
    chk("reset.fetch_req", {31'd0, fb.fetch_req}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("post_reset.fetch_req", {31'd0, fb.fetch_req}, 32'd1);

    // One-byte instruction, decode not ready
    drive(1'b1, 8'h96, 8'h10, 1'b0);
    sb.push_back(mk1(8'h96, 8'h10));
    tick();
    drive(1'b1, 8'hC4, 8'h20, 1'b0);
    #1;
    chk_front("one_byte", 1'b0);
    chk("one_byte.fetch_req", {31'd0, fb.fetch_req}, 32'd0);

    // Stall with memory presenting the next byte
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_front("stall", 1'b0);
      chk("stall.fetch_req", {31'd0, fb.fetch_req}, 32'd0);
    end

    // Decode takes 0x96 while C4 lands as byte1 of LDM
    fb.id_ready = 1'b1;
    #1;
    chk("ldm_b1.fetch_req", {31'd0, fb.fetch_req}, 32'd1);
    void'(sb.pop_front());
    tick();
    chk("ldm_half.valid", {31'd0, fb.if_valid}, 32'd0);
    chk("ldm_half.op", {28'd0, fb.if_opcode}, 32'd12);
    drive(1'b0, 8'hEE, 8'h21, 1'b0);
    tick();
    chk("ldm_wait.valid", {31'd0, fb.if_valid}, 32'd0);
    drive(1'b1, 8'h5A, 8'h21, 1'b0);
    sb.push_back(mk2(8'hC4, 8'h5A, 8'h20));
    tick();
    chk_front("ldm", 1'b0);

    // Back-to-back: decode takes LDM while 0x11 is accepted
    drive(1'b1, 8'h11, 8'h22, 1'b1);
    void'(sb.pop_front());
    sb.push_back(mk1(8'h11, 8'h22));
    tick();
    chk_front("b2b", 1'b0);

    // Next LDM byte1 accepted, then flushed while in HALF
    drive(1'b1, 8'hC0, 8'h23, 1'b1);
    void'(sb.pop_front());
    tick();
    chk("flush_pre.valid", {31'd0, fb.if_valid}, 32'd0);
    fb.flush = 1'b1;
    drive(1'b1, 8'h77, 8'h24, 1'b1);
    #1;
    chk("flush.fetch_req", {31'd0, fb.fetch_req}, 32'd0);
    tick();
    chk_zero("flush");
    fb.flush = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    chk("after_flush.fetch_req", {31'd0, fb.fetch_req}, 32'd1);
    tick();
    chk("after_flush.valid", {31'd0, fb.if_valid}, 32'd0);

    // PC wrap-around FF -> 00 back-to-back
    drive(1'b1, 8'h3F, 8'hFF, 1'b0);
    sb.push_back(mk1(8'h3F, 8'hFF));
    tick();
    chk_front("wrap_ff", 1'b0);
    drive(1'b1, 8'h2B, 8'h00, 1'b1);
    void'(sb.pop_front());
    sb.push_back(mk1(8'h2B, 8'h00));
    tick();
    chk_front("wrap_00", 1'b1);
    drive(1'b0, 8'h00, 8'h01, 1'b1);
    tick();
    chk("drain.valid", {31'd0, fb.if_valid}, 32'd0);

    // Asynchronous reset mid-cycle while FULL
    drive(1'b1, 8'h96, 8'h30, 1'b0);
    sb.push_back(mk1(8'h96, 8'h30));
    tick();
    chk_front("pre_async", 1'b0);
    fb.mem_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk_zero("async_reset");
    chk("async_reset.fetch_req", {31'd0, fb.fetch_req}, 32'd0);
    sb.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("post_async.valid", {31'd0, fb.if_valid}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
